// File: rtl/rect_draw_scheduler_pkg.sv
// Shared types for the rectangle draw scheduler: command layout,
// screen limits and sequencer states.
package draw_pkg;

    localparam int X_W   = 10;
    localparam int Y_W   = 10;
    localparam int W_W   = 10;
    localparam int H_W   = 10;
    localparam int C_W   = 12;
    localparam int CMD_W = X_W + Y_W + W_W + H_W + C_W;

    localparam logic [X_W-1:0] H_RES = 10'd640;
    localparam logic [Y_W-1:0] V_RES = 10'd480;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [W_W-1:0] w;
        logic [H_W-1:0] h;
        logic [C_W-1:0] color;
    } rect_cmd_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    // Empty or fully off-screen rectangles draw nothing.
    function automatic logic cmd_rejected(input rect_cmd_t c);
        return (c.w == '0) || (c.h == '0) ||
               (c.x >= H_RES) || (c.y >= V_RES);
    endfunction

endpackage

// File: rtl/rect_draw_scheduler_if.sv
// Requester command bus and engine command/handshake bundle.
// slave = scheduler side, master = requesters plus engine side.
interface rect_draw_scheduler_if #(
    parameter int NUM_REQ = 4
);
    import draw_pkg::*;

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*CMD_W-1:0] req_cmd;

    logic [X_W-1:0] eng_rect_x;
    logic [Y_W-1:0] eng_rect_y;
    logic [W_W-1:0] eng_rect_width;
    logic [H_W-1:0] eng_rect_height;
    logic [C_W-1:0] eng_rect_color;
    logic           eng_draw_start;
    logic           eng_drawing_done;

    modport slave (
        input  req_valid,
        input  req_cmd,
        output req_ready,
        output eng_rect_x,
        output eng_rect_y,
        output eng_rect_width,
        output eng_rect_height,
        output eng_rect_color,
        output eng_draw_start,
        input  eng_drawing_done
    );

    modport master (
        output req_valid,
        output req_cmd,
        input  req_ready,
        input  eng_rect_x,
        input  eng_rect_y,
        input  eng_rect_width,
        input  eng_rect_height,
        input  eng_rect_color,
        input  eng_draw_start,
        output eng_drawing_done
    );

endinterface

// File: rtl/rect_draw_scheduler_fifo.sv
// Synchronous command FIFO; DEPTH must be a power of two (>= 2)
// so the read/write pointers wrap on their own.
module draw_cmd_fifo
    import draw_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  rect_cmd_t              din,
    input  logic                   pop,
    output rect_cmd_t              dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    rect_cmd_t       r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_level;
    logic            w_wr_en;
    logic            w_rd_en;

    assign full    = (r_level == LVL_FULL);
    assign empty   = (r_level == '0);
    assign level   = r_level;
    assign dout    = r_mem[r_rd_ptr];
    assign w_wr_en = push && !full;
    assign w_rd_en = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/rect_draw_scheduler.sv
// Round-robin sharing of one rectangle engine between NUM_REQ requesters.
// Define FRAME_CLEAR_EN to add a per-frame background clear ahead of queued work.
module rect_draw_scheduler
    import draw_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 20'hFFFFF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    rect_draw_scheduler_if.slave    bus,
    input  logic                    frame_start,
    input  logic [C_W-1:0]          bg_color,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic [7:0]              drop_count,
    output logic                    timeout_err
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

    state_t                  r_state;
    rect_cmd_t               r_eng;
    logic                    r_start;
    logic                    r_tmo;
    logic [TW-1:0]           r_wdog;
    logic [IW-1:0]           r_rr_ptr;
    logic [7:0]              r_drop;

    logic                    w_gnt_vld;
    logic [IW-1:0]           w_gnt_idx;
    logic [IW-1:0]           w_rr_nxt;
    rect_cmd_t               w_gnt_cmd;
    logic                    w_rej;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_empty;
    rect_cmd_t               w_head;
    logic [$clog2(DEPTH):0]  w_level;
    logic                    w_load;
    rect_cmd_t               w_load_cmd;
    logic                    w_wd_expire;

    // Lower-priority wrap-around group first, then the group at/after rr_ptr overrides.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_gnt_cmd = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i] && (IW'(i) < r_rr_ptr)) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = IW'(i);
                w_gnt_cmd = bus.req_cmd[i*CMD_W +: CMD_W];
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i] && (IW'(i) >= r_rr_ptr)) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = IW'(i);
                w_gnt_cmd = bus.req_cmd[i*CMD_W +: CMD_W];
            end
        end
        if (w_full) begin
            w_gnt_vld = 1'b0;
        end
    end

    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_ready[i] = w_gnt_vld && (w_gnt_idx == IW'(i));
        end
    end

    assign w_rr_nxt = (w_gnt_idx == IW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    assign w_rej    = cmd_rejected(w_gnt_cmd);
    assign w_push   = w_gnt_vld && !w_rej;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr <= '0;
            r_drop   <= '0;
        end else if (w_gnt_vld) begin
            r_rr_ptr <= w_rr_nxt;
            if (w_rej && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
        end
    end

    draw_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_push),
        .din     (w_gnt_cmd),
        .pop     (w_pop),
        .dout    (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .level   (w_level)
    );

    assign w_wd_expire = (r_state == WAIT_DONE) && !bus.eng_drawing_done &&
                         (r_wdog == WD_LAST);

`ifdef FRAME_CLEAR_EN
    logic r_clr_pend;
    logic r_clr_act;
    logic w_draw_end;

    assign w_draw_end = (r_state == WAIT_DONE) &&
                        (bus.eng_drawing_done || (r_wdog == WD_LAST));
    assign w_load     = r_clr_pend || !w_empty;
    assign w_load_cmd = r_clr_pend ?
                        '{x: '0, y: '0, w: H_RES, h: V_RES, color: bg_color} :
                        w_head;
    assign w_pop      = (r_state == IDLE) && !w_empty && !r_clr_pend;
`else
    logic w_unused_clr;

    assign w_unused_clr = frame_start ^ (^bg_color);
    assign w_load       = !w_empty;
    assign w_load_cmd   = w_head;
    assign w_pop        = (r_state == IDLE) && !w_empty;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_eng   <= '0;
            r_start <= 1'b0;
            r_tmo   <= 1'b0;
            r_wdog  <= '0;
`ifdef FRAME_CLEAR_EN
            r_clr_pend <= 1'b0;
            r_clr_act  <= 1'b0;
`endif
        end else begin
            r_start <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_load) begin
                        r_eng   <= w_load_cmd;
                        r_start <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_wdog  <= '0;
                    r_state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (bus.eng_drawing_done) begin
                        r_state <= IDLE;
                    end else if (w_wd_expire) begin
                        r_tmo   <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
`ifdef FRAME_CLEAR_EN
            // Flag stays set for the whole clear so repeat pulses fold into it.
            if (w_draw_end && r_clr_act) begin
                r_clr_pend <= 1'b0;
                r_clr_act  <= 1'b0;
            end else if (frame_start) begin
                r_clr_pend <= 1'b1;
            end
            if ((r_state == IDLE) && r_clr_pend) begin
                r_clr_act <= 1'b1;
            end
`endif
        end
    end

    assign bus.eng_rect_x      = r_eng.x;
    assign bus.eng_rect_y      = r_eng.y;
    assign bus.eng_rect_width  = r_eng.w;
    assign bus.eng_rect_height = r_eng.h;
    assign bus.eng_rect_color  = r_eng.color;
    assign bus.eng_draw_start  = r_start;

    assign busy        = (r_state != IDLE) || !w_empty;
    assign fifo_level  = w_level;
    assign drop_count  = r_drop;
    assign timeout_err = r_tmo;

endmodule

// File: tb/tb_rect_draw_scheduler.sv
// Directed bench for rect_draw_scheduler with a small engine model.
// Build with +define+FRAME_CLEAR_EN to include the frame-clear sequence.
module tb_rect_draw_scheduler;
    import draw_pkg::*;

    localparam int NR = 4;
    localparam int DP = 4;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic [11:0] bg_color = '0;
    logic        busy;
    logic [2:0]  fifo_level;
    logic [7:0]  drop_count;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    bit        eng_auto = 1'b1;
    int        eng_delay = 8;
    bit        release_now = 1'b0;
    int        n_start = 0;
    rect_cmd_t starts_q[$];

    rect_draw_scheduler_if #(.NUM_REQ(NR)) bus ();

    rect_draw_scheduler #(
        .NUM_REQ (NR),
        .DEPTH   (DP),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .frame_start (frame_start),
        .bg_color    (bg_color),
        .busy        (busy),
        .fifo_level  (fifo_level),
        .drop_count  (drop_count),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Engine model: log each start, answer done after eng_delay cycles.
    initial begin
        int  cnt;
        bit  pend;
        cnt  = 0;
        pend = 1'b0;
        bus.eng_drawing_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.eng_drawing_done = 1'b0;
            if (bus.eng_draw_start) begin
                starts_q.push_back('{x: bus.eng_rect_x, y: bus.eng_rect_y,
                                     w: bus.eng_rect_width,
                                     h: bus.eng_rect_height,
                                     color: bus.eng_rect_color});
                n_start++;
                pend = 1'b1;
                cnt  = eng_delay;
            end else if (pend) begin
                if (cnt > 0) cnt--;
                if ((eng_auto && cnt == 0) || release_now) begin
                    bus.eng_drawing_done = 1'b1;
                    pend = 1'b0;
                end
            end
        end
    end

    function automatic rect_cmd_t mk(int x, int y, int w, int h, int c);
        rect_cmd_t r;
        r.x = 10'(x);
        r.y = 10'(y);
        r.w = 10'(w);
        r.h = 10'(h);
        r.color = 12'(c);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input rect_cmd_t c);
        bus.req_cmd[i*CMD_W +: CMD_W] = c;
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            #1;
            if (!busy) break;
        end
        chk(tag, busy, 0);
    endtask

    task automatic chk_outputs_zero(input string pfx);
        chk({pfx, "_start"}, bus.eng_draw_start, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_level"}, fifo_level, 0);
        chk({pfx, "_drop"}, drop_count, 0);
        chk({pfx, "_tmo"}, timeout_err, 0);
        chk({pfx, "_ready"}, bus.req_ready, 0);
        chk({pfx, "_eng"}, {bus.eng_rect_x, bus.eng_rect_y, bus.eng_rect_width,
                            bus.eng_rect_height, bus.eng_rect_color}, 0);
    endtask

    initial begin
        int order[5];
        int got;
        int acc;
        int base;
        int idx;

        bus.req_valid = '0;
        bus.req_cmd   = '0;
        foreach (order[k]) order[k] = -1;

        repeat (3) @(negedge clk);
        #1;
        chk_outputs_zero("rst_hold");
        reset_n = 1'b1;
        #1;
        chk_outputs_zero("rst_rel");

        // Round robin with all requesters held valid
        @(negedge clk);
        eng_delay = 1;
        for (int i = 0; i < NR; i++) set_req(i, mk(100 + i, 50, 2, 2, 'h0A0 + i));
        bus.req_valid = 4'hF;
        got = 0;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (bus.req_ready != '0) begin
                idx = -1;
                for (int i = 0; i < NR; i++) if (bus.req_ready[i]) idx = i;
                order[got] = idx;
                got++;
                if (got == 5) break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        bus.req_valid = '0;
        chk("rr_count", got, 5);
        chk("rr_g0", order[0], 0);
        chk("rr_g1", order[1], 1);
        chk("rr_g2", order[2], 2);
        chk("rr_g3", order[3], 3);
        chk("rr_g4", order[4], 0);
        wait_idle("rr_idle", 200);
        chk("rr_starts", n_start, 5);
        chk("rr_last_x", starts_q[4].x, 100);

        // Single command latency and field capture
        eng_delay = 8;
        base = n_start;
        @(negedge clk);
        set_req(0, mk(10, 20, 4, 2, 'hF00));
        bus.req_valid = 4'b0001;
        #1;
        chk("single_ready", bus.req_ready, 4'b0001);
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        chk("single_no_start", bus.eng_draw_start, 0);
        chk("single_level1", fifo_level, 1);
        @(negedge clk);
        #1;
        chk("single_start", bus.eng_draw_start, 1);
        chk("single_fields", {bus.eng_rect_x, bus.eng_rect_y, bus.eng_rect_width,
                              bus.eng_rect_height, bus.eng_rect_color},
            mk(10, 20, 4, 2, 'hF00));
        @(negedge clk);
        #1;
        chk("single_pulse", bus.eng_draw_start, 0);
        wait_idle("single_idle", 50);
        chk("single_nstart", n_start - base, 1);

        // FIFO full with engine stalled
        @(negedge clk);
        eng_auto = 1'b0;
        base = n_start;
        set_req(0, mk(30, 30, 5, 5, 'h00F));
        bus.req_valid = 4'b0001;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (bus.req_ready[0]) acc++;
            @(negedge clk);
        end
        #1;
        chk("full_accepted", acc, 5);
        chk("full_level", fifo_level, 4);
        chk("full_ready0", bus.req_ready, 0);
        chk("full_one_start", n_start - base, 1);
        eng_auto = 1'b1;
        eng_delay = 2;
        release_now = 1'b1;
        @(negedge clk);
        #1;
        release_now = 1'b0;
        chk("full_ready_still0", bus.req_ready, 0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (bus.req_ready[0]) break;
        end
        chk("full_ready_after_done", bus.req_ready, 4'b0001);
        bus.req_valid = '0;
        wait_idle("full_drain", 200);
        chk("full_no_tmo", timeout_err, 0);
        chk("full_nstart", n_start - base, 5);

        // Filtering of degenerate and off-screen commands
        base = n_start;
        chk("filt_drop0", drop_count, 0);
        @(negedge clk);
        set_req(1, mk(50, 50, 0, 5, 'h111));
        bus.req_valid = 4'b0010;
        #1;
        chk("filt_ack_w0", bus.req_ready, 4'b0010);
        @(negedge clk);
        set_req(2, mk(640, 10, 5, 5, 'h222));
        bus.req_valid = 4'b0100;
        #1;
        chk("filt_ack_x640", bus.req_ready, 4'b0100);
        @(negedge clk);
        set_req(3, mk(50, 50, 5, 0, 'h333));
        bus.req_valid = 4'b1000;
        #1;
        chk("filt_ack_h0", bus.req_ready, 4'b1000);
        @(negedge clk);
        bus.req_valid = '0;
        repeat (5) @(negedge clk);
        #1;
        chk("filt_drop3", drop_count, 3);
        chk("filt_level0", fifo_level, 0);
        chk("filt_no_start", n_start - base, 0);

        // Partially off-screen command is queued unchanged
        @(negedge clk);
        set_req(0, mk(639, 479, 10, 10, 'hABC));
        bus.req_valid = 4'b0001;
        @(negedge clk);
        bus.req_valid = '0;
        wait_idle("edge_idle", 50);
        chk("edge_started", n_start - base, 1);
        chk("edge_fields", starts_q[n_start-1], mk(639, 479, 10, 10, 'hABC));
        chk("edge_drop", drop_count, 3);

        // Drop counter saturation
        base = n_start;
        @(negedge clk);
        set_req(0, mk(700, 0, 1, 1, 0));
        bus.req_valid = 4'b0001;
        repeat (300) @(negedge clk);
        bus.req_valid = '0;
        #1;
        chk("sat_drop255", drop_count, 8'd255);
        chk("sat_no_start", n_start - base, 0);

        // Watchdog timeout, then next queued command still issues
        @(negedge clk);
        eng_auto = 1'b0;
        base = n_start;
        set_req(0, mk(1, 1, 1, 1, 1));
        bus.req_valid = 4'b0001;
        @(negedge clk);
        set_req(1, mk(2, 2, 2, 2, 2));
        bus.req_valid = 4'b0010;
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        for (int c = 0; c < 10; c++) begin
            if (bus.eng_draw_start) break;
            @(negedge clk);
            #1;
        end
        chk("tmo_start", bus.eng_draw_start, 1);
        chk("tmo_first_x", bus.eng_rect_x, 1);
        repeat (16) @(negedge clk);
        #1;
        chk("tmo_not_early", timeout_err, 0);
        @(negedge clk);
        #1;
        chk("tmo_set", timeout_err, 1);
        eng_auto = 1'b1;
        eng_delay = 2;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (n_start - base >= 2) break;
        end
        chk("tmo_next_issued", n_start - base, 2);
        chk("tmo_next_x", starts_q[n_start-1].x, 2);
        wait_idle("tmo_idle", 50);
        chk("tmo_sticky", timeout_err, 1);

`ifdef FRAME_CLEAR_EN
        // Frame clear jumps ahead of two queued commands
        @(negedge clk);
        eng_auto = 1'b0;
        base = n_start;
        bg_color = 12'h5A5;
        set_req(0, mk(3, 3, 3, 3, 3));
        bus.req_valid = 4'b0001;
        @(negedge clk);
        set_req(1, mk(4, 4, 4, 4, 4));
        bus.req_valid = 4'b0010;
        @(negedge clk);
        set_req(2, mk(5, 5, 5, 5, 5));
        bus.req_valid = 4'b0100;
        @(negedge clk);
        bus.req_valid = '0;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
        #1;
        eng_auto = 1'b1;
        eng_delay = 2;
        release_now = 1'b1;
        @(negedge clk);
        #1;
        release_now = 1'b0;
        wait_idle("clr_idle", 100);
        chk("clr_count", n_start - base, 4);
        chk("clr_first_cmd", starts_q[base], mk(3, 3, 3, 3, 3));
        chk("clr_rect", starts_q[base+1], mk(0, 0, 640, 480, 'h5A5));
        chk("clr_q_first", starts_q[base+2], mk(4, 4, 4, 4, 4));
        chk("clr_q_second", starts_q[base+3], mk(5, 5, 5, 5, 5));
`endif

        // Reset mid WAIT_DONE with three commands queued
        @(negedge clk);
        eng_auto = 1'b0;
        set_req(0, mk(7, 7, 7, 7, 7));
        bus.req_valid = 4'b0001;
        repeat (4) @(negedge clk);
        bus.req_valid = '0;
        #1;
        chk("rst_pre_level", fifo_level, 3);
        chk("rst_pre_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        chk_outputs_zero("rst_mid");
        @(negedge clk);
        reset_n = 1'b1;
        base = n_start;
        repeat (20) @(negedge clk);
        #1;
        chk("rst_post_nostart", n_start - base, 0);
        chk("rst_post_busy", busy, 0);
        chk("rst_post_level", fifo_level, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
